regfile_wb_arbiter: RTL and testbench

- Shares the register file's single synchronous write port between N_REQ writeback requesters: ALU (index 0), ID immediate/load-upper (index 1), MEM load (index 2).
- Arbitrates round-robin with a valid/ready handshake and registers the winning write onto wb_enable/wb_addr/wb_data, which drive the register file's write port.
- Keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards on its two read addresses.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: geometry and
// requester indices (ALU, ID immediate/load-upper, MEM load).
package regfile_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NREGS   = 2 ** ADDR_W;
    localparam int unsigned N_REQ   = 3;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_ID  = 1;
    localparam int unsigned REQ_MEM = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot combinational grant, search
// starting at the pointer, pointer advances past each winner.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);
    import regfile_pkg::*;

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_rr_ptr;
    logic             w_any;
    int unsigned      w_dist;
    int unsigned      w_best;
    int unsigned      w_win;

    // Winner is the valid requester with the smallest distance from the pointer.
    always_comb begin
        w_best = N;
        w_win  = 0;
        w_dist = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_dist = (i + N - 32'(r_rr_ptr)) % N;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = i;
            end
        end
        w_any   = !rst && (w_best < N);
        o_grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_any && (w_win == i)) begin
                o_grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= PTR_W'((w_win + 1) % N);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Define WB_BYPASS_EN to add fwd_hit/fwd_data forwarding outputs.
module regfile_wb_arbiter #(
    parameter int unsigned N_REQ  = regfile_pkg::N_REQ,
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         q_addr_0,
    input  logic [ADDR_W-1:0]         q_addr_1,
    output logic                      q_busy_0,
    output logic                      q_busy_1,
    output logic                      wb_enable,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic [(2**ADDR_W)-1:0]    pending
`ifdef WB_BYPASS_EN
    ,
    output logic                      fwd_hit_0,
    output logic                      fwd_hit_1,
    output logic [DATA_W-1:0]         fwd_data_0,
    output logic [DATA_W-1:0]         fwd_data_1
`endif
);
    import regfile_pkg::*;

    localparam int unsigned NR = 2 ** ADDR_W;

    logic [N_REQ-1:0]  w_grant;
    logic              w_hs;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NR-1:0]     w_pending_nxt;
    logic              w_hit_0;
    logic              w_hit_1;

    logic              r_wb_en;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [NR-1:0]     r_pending;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req_valid),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Set is applied after clear so a same-edge reserve of the retiring register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_wb_en) begin
            w_pending_nxt[r_wb_addr] = 1'b0;
        end
        if (rsv_valid) begin
            w_pending_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_pending <= '0;
        end else begin
            r_wb_en   <= w_hs;
            r_pending <= w_pending_nxt;
            if (w_hs) begin
                r_wb_addr <= w_sel_addr;
                r_wb_data <= w_sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign w_hit_0    = r_wb_en && (r_wb_addr == q_addr_0);
    assign w_hit_1    = r_wb_en && (r_wb_addr == q_addr_1);
    assign fwd_hit_0  = w_hit_0;
    assign fwd_hit_1  = w_hit_1;
    assign fwd_data_0 = r_wb_data;
    assign fwd_data_1 = r_wb_data;
`else
    assign w_hit_0 = 1'b0;
    assign w_hit_1 = 1'b0;
`endif

    assign q_busy_0  = r_pending[q_addr_0] & ~w_hit_0;
    assign q_busy_1  = r_pending[q_addr_1] & ~w_hit_1;
    assign wb_enable = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign pending   = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: fixed vector table, hand-written scoreboard,
// bypass and reset sequences, then randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [8:0]  req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [2:0]  rsv_addr;
    logic [2:0]  q_addr_0, q_addr_1;
    logic        q_busy_0, q_busy_1;
    logic        wb_enable;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  pending;
`ifdef WB_BYPASS_EN
    logic        fwd_hit_0, fwd_hit_1;
    logic [31:0] fwd_data_0, fwd_data_1;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(3), .DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .q_addr_0(q_addr_0), .q_addr_1(q_addr_1),
        .q_busy_0(q_busy_0), .q_busy_1(q_busy_1),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending(pending)
`ifdef WB_BYPASS_EN
        , .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
        .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] v, input logic [8:0] a,
                         input logic [95:0] d, input logic rv, input logic [2:0] ra,
                         input logic [2:0] q0, input logic [2:0] q1);
        @(negedge clk);
        rst = r; req_valid = v; req_addr = a; req_data = d;
        rsv_valid = rv; rsv_addr = ra; q_addr_0 = q0; q_addr_1 = q1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [2:0]  a0;
        logic [31:0] d0;
        logic [2:0]  exp_ready;
        logic        exp_en;
        logic [2:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [2:0] a0,
                                input logic [31:0] d0, input logic [2:0] er, input logic ee,
                                input logic [2:0] ea, input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.a0 = a0; t.d0 = d0;
        t.exp_ready = er; t.exp_en = ee; t.exp_addr = ea; t.exp_data = ed;
        return t;
    endfunction

    // Reference model state
    int unsigned m_ptr;
    logic [7:0]  m_pend;
    logic        m_en;
    logic [2:0]  m_addr;
    logic [31:0] m_data;

    function automatic int winner(input logic [2:0] v);
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (int'(m_ptr) + k) % 3;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    vec_t        tbl[19];
    logic [2:0]  cur_a[3];
    logic [31:0] cur_d[3];
    logic [2:0]  cur_v;
    logic [2:0]  gm;

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; q_addr_0 = '0; q_addr_1 = '0;

        // Requester 1/2 fixed at addr 2/4, data 2222.../3333...
        tbl[0]  = mk(1, 3'b000, 3'd1, 32'h11111111, 3'b000, 0, 3'd0, 32'h0);
        tbl[1]  = mk(1, 3'b111, 3'd1, 32'h11111111, 3'b000, 0, 3'd0, 32'h0);
        tbl[2]  = mk(0, 3'b000, 3'd1, 32'h11111111, 3'b000, 0, 3'd0, 32'h0);
        tbl[3]  = mk(0, 3'b001, 3'd3, 32'hDEADBEEF, 3'b001, 1, 3'd3, 32'hDEADBEEF);
        tbl[4]  = mk(0, 3'b000, 3'd1, 32'h11111111, 3'b000, 0, 3'd3, 32'hDEADBEEF);
        tbl[5]  = mk(1, 3'b000, 3'd1, 32'h11111111, 3'b000, 0, 3'd0, 32'h0);
        tbl[6]  = mk(0, 3'b111, 3'd1, 32'h11111111, 3'b001, 1, 3'd1, 32'h11111111);
        tbl[7]  = mk(0, 3'b111, 3'd1, 32'h11111111, 3'b010, 1, 3'd2, 32'h22222222);
        tbl[8]  = mk(0, 3'b111, 3'd1, 32'h11111111, 3'b100, 1, 3'd4, 32'h33333333);
        tbl[9]  = mk(0, 3'b111, 3'd1, 32'h11111111, 3'b001, 1, 3'd1, 32'h11111111);
        tbl[10] = mk(0, 3'b111, 3'd1, 32'h11111111, 3'b010, 1, 3'd2, 32'h22222222);
        tbl[11] = mk(0, 3'b111, 3'd1, 32'h11111111, 3'b100, 1, 3'd4, 32'h33333333);
        tbl[12] = mk(0, 3'b011, 3'd1, 32'h11111111, 3'b001, 1, 3'd1, 32'h11111111);
        tbl[13] = mk(0, 3'b010, 3'd1, 32'h11111111, 3'b010, 1, 3'd2, 32'h22222222);
        tbl[14] = mk(0, 3'b000, 3'd1, 32'h11111111, 3'b000, 0, 3'd2, 32'h22222222);
        tbl[15] = mk(0, 3'b011, 3'd1, 32'h11111111, 3'b001, 1, 3'd1, 32'h11111111);
        tbl[16] = mk(0, 3'b110, 3'd1, 32'h11111111, 3'b010, 1, 3'd2, 32'h22222222);
        tbl[17] = mk(0, 3'b100, 3'd1, 32'h11111111, 3'b100, 1, 3'd4, 32'h33333333);
        tbl[18] = mk(0, 3'b000, 3'd1, 32'h11111111, 3'b000, 0, 3'd4, 32'h33333333);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].valid, {3'd4, 3'd2, tbl[i].a0},
                  {32'h33333333, 32'h22222222, tbl[i].d0}, 0, 3'd0, 3'd0, 3'd0);
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            tick();
            chk($sformatf("vec%0d wb_enable", i), 32'(wb_enable), 32'(tbl[i].exp_en));
            chk($sformatf("vec%0d wb_addr", i), 32'(wb_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("vec%0d wb_data", i), wb_data, tbl[i].exp_data);
            chk($sformatf("vec%0d pending", i), 32'(pending), 32'h0);
        end

        // Scoreboard: reserve 5, MEM writes 5, busy through the wb_enable cycle
        drive(1, 3'b000, '0, '0, 0, 3'd0, 3'd5, 3'd0); tick();
        drive(0, 3'b000, '0, '0, 1, 3'd5, 3'd5, 3'd0);
        chk("sb busy before rsv", 32'(q_busy_0), 32'h0);
        tick();
        chk("sb pending after rsv", 32'(pending), 32'h20);
        drive(0, 3'b100, {3'd5, 6'd0}, {32'hCAFEF00D, 64'h0}, 0, 3'd0, 3'd5, 3'd0);
        chk("sb mem ready", 32'(req_ready), 32'h4);
        chk("sb busy pending", 32'(q_busy_0), 32'h1);
        tick();
        chk("sb wb_enable", 32'(wb_enable), 32'h1);
        chk("sb wb_addr", 32'(wb_addr), 32'h5);
        chk("sb wb_data", wb_data, 32'hCAFEF00D);
        chk("sb pending in wb cycle", 32'(pending), 32'h20);
        drive(0, 3'b000, '0, '0, 0, 3'd0, 3'd5, 3'd0);
        chk("sb busy wb cycle", 32'(q_busy_0), BYP ? 32'h0 : 32'h1);
        tick();
        chk("sb pending cleared", 32'(pending), 32'h0);
        drive(0, 3'b000, '0, '0, 0, 3'd0, 3'd5, 3'd0);
        chk("sb busy after clear", 32'(q_busy_0), 32'h0);
        tick();

        // Same-edge reserve and clear of register 5
        drive(0, 3'b000, '0, '0, 1, 3'd5, 3'd5, 3'd0); tick();
        drive(0, 3'b100, {3'd5, 6'd0}, {32'h0BADCAFE, 64'h0}, 0, 3'd0, 3'd5, 3'd0);
        chk("same-edge mem ready", 32'(req_ready), 32'h4);
        tick();
        drive(0, 3'b000, '0, '0, 1, 3'd5, 3'd5, 3'd0);
        tick();
        chk("same-edge set wins", 32'(pending), 32'h20);
        drive(0, 3'b000, '0, '0, 0, 3'd0, 3'd5, 3'd0);
        tick();
        chk("same-edge bit holds", 32'(pending), 32'h20);
        chk("same-edge wb idle", 32'(wb_enable), 32'h0);

        // Forwarding window on read port 1 (register 2)
        drive(0, 3'b000, '0, '0, 1, 3'd2, 3'd0, 3'd0); tick();
        chk("byp pending", 32'(pending), 32'h24);
        drive(0, 3'b001, {6'd0, 3'd2}, {64'h0, 32'h12345678}, 0, 3'd0, 3'd0, 3'd0);
        tick();
        chk("byp wb_addr", 32'(wb_addr), 32'h2);
        drive(0, 3'b000, '0, '0, 0, 3'd0, 3'd5, 3'd2);
        chk("byp busy1", 32'(q_busy_1), BYP ? 32'h0 : 32'h1);
        chk("byp busy0 other reg", 32'(q_busy_0), 32'h1);
`ifdef WB_BYPASS_EN
        chk("byp fwd_hit_1", 32'(fwd_hit_1), 32'h1);
        chk("byp fwd_data_1", fwd_data_1, 32'h12345678);
        chk("byp fwd_hit_0", 32'(fwd_hit_0), 32'h0);
`endif
        tick();
        chk("byp pending after", 32'(pending), 32'h20);

        // Reset during an ID request; pointer was 1, ALU must win afterwards
        drive(1, 3'b010, {3'd0, 3'd6, 3'd0}, {32'h0, 32'hAAAA0001, 32'h0}, 1, 3'd7, 3'd0, 3'd0);
        chk("rst ready low", 32'(req_ready), 32'h0);
        tick();
        chk("rst wb_enable", 32'(wb_enable), 32'h0);
        chk("rst pending", 32'(pending), 32'h0);
        drive(0, 3'b011, {3'd0, 3'd6, 3'd1}, {32'h0, 32'hAAAA0001, 32'hBBBB0002}, 0, 3'd0, 3'd0, 3'd0);
        chk("rst alu wins", 32'(req_ready), 32'h1);
        tick();
        chk("rst alu wb_addr", 32'(wb_addr), 32'h1);

        // Randomized traffic against the reference model
        cur_v = '0; gm = '0;
        for (int i = 0; i < 3; i++) begin cur_a[i] = '0; cur_d[i] = '0; end
        for (int k = 0; k < 400; k++) begin
            int w;
            logic [2:0] er;
            logic r, rv;
            logic [2:0] ra, q0, q1;
            logic [8:0] pa;
            logic [95:0] pd;
            for (int i = 0; i < 3; i++) begin
                if (!cur_v[i] || gm[i]) begin
                    cur_v[i] = ($urandom_range(0, 99) < 60);
                    cur_a[i] = 3'($urandom_range(0, 7));
                    cur_d[i] = $urandom;
                end
                pa[i*3 +: 3]  = cur_a[i];
                pd[i*32 +: 32] = cur_d[i];
            end
            r  = (k == 0) || ($urandom_range(0, 59) == 0);
            rv = ($urandom_range(0, 99) < 35);
            ra = 3'($urandom_range(0, 7));
            q0 = ($urandom_range(0, 3) == 0) ? m_addr : 3'($urandom_range(0, 7));
            q1 = ($urandom_range(0, 3) == 0) ? m_addr : 3'($urandom_range(0, 7));
            drive(r, cur_v, pa, pd, rv, ra, q0, q1);
            w  = r ? -1 : winner(cur_v);
            er = (w >= 0) ? 3'(1 << w) : 3'b000;
            if (k > 0) begin
                chk("rnd ready", 32'(req_ready), 32'(er));
                chk("rnd busy0", 32'(q_busy_0), 32'(m_pend[q0] & ~(BYP & m_en & (m_addr == q0))));
                chk("rnd busy1", 32'(q_busy_1), 32'(m_pend[q1] & ~(BYP & m_en & (m_addr == q1))));
`ifdef WB_BYPASS_EN
                chk("rnd fwd_hit_0", 32'(fwd_hit_0), 32'(m_en & (m_addr == q0)));
                chk("rnd fwd_data_1", fwd_data_1, m_data);
`endif
            end
            tick();
            if (r) begin
                m_ptr = 0; m_pend = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
            end else begin
                if (m_en) m_pend[m_addr] = 1'b0;
                if (rv) m_pend[ra] = 1'b1;
                m_en = (w >= 0);
                if (w >= 0) begin
                    m_addr = cur_a[w];
                    m_data = cur_d[w];
                    m_ptr  = (w + 1) % 3;
                end
            end
            gm = er;
            chk("rnd wb_enable", 32'(wb_enable), 32'(m_en));
            chk("rnd wb_addr", 32'(wb_addr), 32'(m_addr));
            chk("rnd wb_data", wb_data, m_data);
            chk("rnd pending", 32'(pending), 32'(m_pend));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
